// File: rtl/spi_mem_pkg.sv
// Shared constants and state encoding for the SPI serial-SRAM responder.
package spi_mem_pkg;

    localparam int unsigned ADDR_W  = 24;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CNT_W   = 5;

    localparam logic [BYTE_W-1:0] CMD_READ   = 8'h03;
    localparam logic [BYTE_W-1:0] CMD_WRITE  = 8'h02;
    localparam logic [BYTE_W-1:0] CMD_RDSR   = 8'h05;
    localparam logic [BYTE_W-1:0] CMD_WRSR   = 8'h01;
    localparam logic [BYTE_W-1:0] STATUS_SEQ = 8'h40;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RDATA,
        WDATA,
        IGNORE
    } state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// Synchronizes sclk/cs_n/mosi into clk and produces aligned sclk edge strobes.
module spi_slave_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic cs_n_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic sclk_prev_q, sclk_prev_d;
    logic cs_n_q, cs_n_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;
    logic mosi_q, mosi_d;

    always_comb begin
        sclk_sync_d = SYNC_STAGES'({sclk_sync_q, sclk});
        cs_sync_d   = SYNC_STAGES'({cs_sync_q, cs_n});
        mosi_sync_d = SYNC_STAGES'({mosi_sync_q, mosi});
        sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
        rise_d      = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
        fall_d      = ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
        cs_n_d      = cs_sync_q[SYNC_STAGES-1];
        mosi_d      = mosi_sync_q[SYNC_STAGES-1];
    end

    // cs_n resets as "selected" so a select held low across reset never looks like a new falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_n_q      <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_n_q      <= cs_n_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            mosi_q      <= mosi_d;
        end
    end

    assign cs_n_s    = cs_n_q;
    assign sclk_rise = rise_q;
    assign sclk_fall = fall_q;
    assign mosi_s    = mosi_q;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 responder emulating a 23LC-style serial SRAM (READ/WRITE, sequential mode).
// Define SPI_MEM_RDSR_EN to accept read-status (0x05) and write-status (0x01).
module spi_mem_responder
    import spi_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 cs_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    output logic                 active,
    output logic                 wr_pulse,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [7:0]           wr_data
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic cs_n_s, sclk_rise, sclk_fall, mosi_s;

    spi_slave_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .cs_n_s   (cs_n_s),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall),
        .mosi_s   (mosi_s)
    );

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0]      shift_q, shift_d;
    logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
    logic [2:0]             tx_bit_q, tx_bit_d;
    logic                   rd_flag_q, rd_flag_d;
    logic                   status_q, status_d;
    logic                   discard_q, discard_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic                   active_q, active_d;
    logic                   wr_pulse_q, wr_pulse_d;
    logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
    logic [BYTE_W-1:0]      wr_data_q, wr_data_d;
    logic [BYTE_W-1:0]      rd_byte_q;
    logic [BYTE_W-1:0]      mem_q [DEPTH];
    logic [ADDR_W-1:0]      shift_nxt_c;
    logic [BYTE_W-1:0]      tx_byte_c;

    always_comb begin
        shift_nxt_c = {shift_q[ADDR_W-2:0], mosi_s};
        tx_byte_c   = status_q ? STATUS_SEQ : rd_byte_q;

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        tx_bit_d   = tx_bit_q;
        rd_flag_d  = rd_flag_q;
        status_d   = status_q;
        discard_d  = discard_q;
        miso_d     = miso_q;
        miso_oe_d  = miso_oe_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        cs_prev_d  = cs_n_s;

        // Deselect wins over everything, including a coincident sclk edge
        if (cs_n_s) begin
            state_d   = IDLE;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    if (cs_prev_q) begin
                        state_d   = CMD;
                        bit_cnt_d = '0;
                        status_d  = 1'b0;
                        discard_d = 1'b0;
                    end
                end
                CMD: if (sclk_rise) begin
                    shift_d   = shift_nxt_c;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(7)) begin
                        bit_cnt_d = '0;
                        tx_bit_d  = '0;
                        case (shift_nxt_c[BYTE_W-1:0])
                            CMD_READ:  begin state_d = ADDR; rd_flag_d = 1'b1; end
                            CMD_WRITE: begin state_d = ADDR; rd_flag_d = 1'b0; end
`ifdef SPI_MEM_RDSR_EN
                            CMD_RDSR:  begin state_d = RDATA; status_d = 1'b1; end
                            CMD_WRSR:  begin state_d = WDATA; discard_d = 1'b1; end
`endif
                            default:   state_d = IGNORE;
                        endcase
                    end
                end
                ADDR: if (sclk_rise) begin
                    shift_d   = shift_nxt_c;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                        bit_cnt_d = '0;
                        tx_bit_d  = '0;
                        ptr_d     = shift_nxt_c[ADDR_BITS-1:0];
                        state_d   = rd_flag_q ? RDATA : WDATA;
                    end
                end
                RDATA: if (sclk_fall) begin
                    miso_oe_d = 1'b1;
                    miso_d    = tx_byte_c[~tx_bit_q];
                    tx_bit_d  = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7 && !status_q) begin
                        ptr_d = ptr_q + ADDR_BITS'(1);
                    end
                end
                WDATA: if (sclk_rise) begin
                    shift_d   = shift_nxt_c;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(7)) begin
                        bit_cnt_d = '0;
                        if (discard_q) begin
                            state_d = IGNORE;
                        end else begin
                            wr_pulse_d = 1'b1;
                            wr_addr_d  = ptr_q;
                            wr_data_d  = shift_nxt_c[BYTE_W-1:0];
                            ptr_d      = ptr_q + ADDR_BITS'(1);
                        end
                    end
                end
                IGNORE: begin
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end

        active_d = !cs_n_s && (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            tx_bit_q   <= '0;
            rd_flag_q  <= 1'b0;
            status_q   <= 1'b0;
            discard_q  <= 1'b0;
            cs_prev_q  <= 1'b0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            active_q   <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            tx_bit_q   <= tx_bit_d;
            rd_flag_q  <= rd_flag_d;
            status_q   <= status_d;
            discard_q  <= discard_d;
            cs_prev_q  <= cs_prev_d;
            miso_q     <= miso_d;
            miso_oe_q  <= miso_oe_d;
            active_q   <= active_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Byte array: contents survive reset; read port tracks the next pointer so data is ready one clk after entry
    always_ff @(posedge clk) begin
        if (wr_pulse_q) begin
            mem_q[wr_addr_q] <= wr_data_q;
        end
        rd_byte_q <= mem_q[ptr_d];
    end

    assign miso     = miso_q;
    assign miso_oe  = miso_oe_q;
    assign active   = active_q;
    assign wr_pulse = wr_pulse_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Self-checking bench for spi_mem_responder: directed table, corner sequences and random write/read-back.
module tb_spi_mem_responder;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst, sclk, cs_n, mosi;
    logic       miso, miso_oe, active, wr_pulse;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;

    always #5 clk = ~clk;

    spi_mem_responder dut (
        .clk     (clk),
        .rst     (rst),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .active  (active),
        .wr_pulse(wr_pulse),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  model_mem   [1024];
    bit          model_valid [1024];
    logic [17:0] wr_seen [$];

    always @(negedge clk) begin
        if (wr_pulse) wr_seen.push_back({wr_addr, wr_data});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One chip-select framed transfer; checks miso_oe/miso shape, write strobes and read data against the model
    task automatic run(input logic [7:0] cmd, input logic [23:0] addr, input int nbytes,
                       input logic [31:0] wdata, input int extra, input int rst_bit,
                       output logic [31:0] rd_word);
        logic [63:0] txv;
        int          nbits, dstart, bad_oe, bad_idle, exp_wr, a;
        bit          rd_mode, has_addr, exp_oe;
        bit          oe_b [128];
        bit          mi_b [128];
        logic [7:0]  eb;

        has_addr = (cmd == 8'h03) || (cmd == 8'h02);
        rd_mode  = (cmd == 8'h03);
`ifdef SPI_MEM_RDSR_EN
        if (cmd == 8'h05) rd_mode = 1'b1;
`endif
        dstart  = has_addr ? 32 : 8;
        nbits   = dstart + 8 * nbytes + extra;
        txv     = has_addr ? {cmd, addr, wdata} : {cmd, wdata, 24'h0};
        rd_word = '0;
        wr_seen.delete();

        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int j = 0; j < nbits; j++) begin
            mosi = (j < 64) ? txv[63 - j] : 1'b0;
            repeat (HALF) @(negedge clk);
            oe_b[j] = miso_oe;
            mi_b[j] = miso;
            if (j == 4 && (rst_bit < 0 || rst_bit > 4)) check("active_mid", 32'(active), 32'd1);
            if (j == rst_bit) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_oe_miso", 32'({miso_oe, miso}), 32'd0);
            end
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        mosi = 1'b0;
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        check("active_end", 32'(active), 32'd0);

        bad_oe   = 0;
        bad_idle = 0;
        for (int j = 0; j < nbits; j++) begin
            exp_oe = rd_mode && (j >= dstart) && (rst_bit < 0 || j <= rst_bit);
            if (oe_b[j] != exp_oe) bad_oe++;
            if (!exp_oe && mi_b[j]) bad_idle++;
            if (j >= dstart && j < dstart + 32) rd_word[31 - (j - dstart)] = mi_b[j];
        end
        check("oe_pattern", 32'(bad_oe), 32'd0);
        check("miso_idle", 32'(bad_idle), 32'd0);

        exp_wr = (cmd == 8'h02 && rst_bit < 0) ? nbytes : 0;
        check("wr_count", 32'(wr_seen.size()), 32'(exp_wr));
        for (int i = 0; i < exp_wr; i++) begin
            a = (int'(addr) + i) % 1024;
            if (i < wr_seen.size()) check("wr_event", 32'(wr_seen[i]), 32'({a[9:0], wdata[31 - 8 * i -: 8]}));
            model_mem[a]   = wdata[31 - 8 * i -: 8];
            model_valid[a] = 1'b1;
        end

        if (rd_mode && rst_bit < 0) begin
            for (int k = 0; k < nbytes && k < 4; k++) begin
                a  = (int'(addr) + k) % 1024;
                eb = (cmd == 8'h05) ? 8'h40 : model_mem[a];
                if (cmd == 8'h05 || model_valid[a]) check("rd_byte", 32'(rd_word[31 - 8 * k -: 8]), 32'(eb));
            end
        end
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          nbytes;
        logic [31:0] wdata;
        int          extra;
        logic [31:0] exp_rd;
        logic [31:0] mask;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] rd;
    logic [23:0] raddr;
    int          rn, rx;
    logic [31:0] rdat;

    initial begin
        vecs[0] = '{8'h02, 24'h000010, 4, 32'hDEADBEEF, 0, 32'h0,        32'h0};
        vecs[1] = '{8'h03, 24'h000010, 4, 32'h0,        0, 32'hDEADBEEF, 32'hFFFFFFFF};
        vecs[2] = '{8'h02, 24'h0003FF, 2, 32'h11220000, 0, 32'h0,        32'h0};
        vecs[3] = '{8'h03, 24'h000000, 1, 32'h0,        0, 32'h22000000, 32'hFF000000};
        vecs[4] = '{8'h02, 24'h000021, 1, 32'h66000000, 0, 32'h0,        32'h0};
        vecs[5] = '{8'h02, 24'h000020, 1, 32'h55F00000, 5, 32'h0,        32'h0};
        vecs[6] = '{8'h03, 24'h000020, 2, 32'h0,        0, 32'h55660000, 32'hFFFF0000};
        vecs[7] = '{8'h9F, 24'h000000, 4, 32'hFFFFFFFF, 0, 32'h0,        32'h0};
        vecs[8] = '{8'h03, 24'hABC3FF, 1, 32'h0,        0, 32'h11000000, 32'hFF000000};
        vecs[9] = '{8'h03, 24'h000011, 2, 32'h0,        0, 32'hADBE0000, 32'hFFFF0000};

        rst  = 1'b1;
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_miso", 32'(miso), 32'd0);
        check("reset_oe", 32'(miso_oe), 32'd0);
        check("reset_active", 32'(active), 32'd0);
        check("reset_wr_pulse", 32'(wr_pulse), 32'd0);
        check("reset_wr_addr", 32'(wr_addr), 32'd0);
        check("reset_wr_data", 32'(wr_data), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run(vecs[i].cmd, vecs[i].addr, vecs[i].nbytes, vecs[i].wdata, vecs[i].extra, -1, rd);
            if (vecs[i].mask != 0) check($sformatf("vec%0d_read", i), rd & vecs[i].mask, vecs[i].exp_rd & vecs[i].mask);
        end

        // Reset during the 3rd data bit of a read, then a clean read afterwards
        run(8'h03, 24'h000010, 4, 32'h0, 0, 34, rd);
        check("rst_partial_bits", 32'(rd[31:29]), 32'b110);
        check("rst_tail_zero", rd & 32'h1FFFFFFF, 32'h0);
        run(8'h03, 24'h000010, 1, 32'h0, 0, -1, rd);
        check("post_rst_read", 32'(rd[31:24]), 32'hDE);

        run(8'h05, 24'h0, 2, 32'h0, 0, -1, rd);
`ifdef SPI_MEM_RDSR_EN
        check("rdsr_bytes", 32'(rd[31:16]), 32'h4040);
`else
        check("rdsr_disabled", 32'(rd[31:16]), 32'h0);
`endif

        for (int it = 0; it < 12; it++) begin
            raddr = 24'($urandom);
            rn    = int'($urandom_range(1, 4));
            rdat  = $urandom;
            rx    = int'($urandom_range(0, 7));
            run(8'h02, raddr, rn, rdat, rx, -1, rd);
            run(8'h03, raddr, rn, 32'h0, 0, -1, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
